// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared opcodes, FSM states and instruction field helpers for acc_cpu
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI    = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADDI   = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUBI   = 4'h3;
  localparam logic [OPC_W-1:0] OP_ANDI   = 4'h4;
  localparam logic [OPC_W-1:0] OP_ORI    = 4'h5;
  localparam logic [OPC_W-1:0] OP_XORI   = 4'h6;
  localparam logic [OPC_W-1:0] OP_LDA    = 4'h7;
  localparam logic [OPC_W-1:0] OP_STA    = 4'h8;
  localparam logic [OPC_W-1:0] OP_ADDM   = 4'h9;
  localparam logic [OPC_W-1:0] OP_JMP    = 4'hA;
  localparam logic [OPC_W-1:0] OP_JZ     = 4'hB;
  localparam logic [OPC_W-1:0] OP_JC     = 4'hC;
  localparam logic [OPC_W-1:0] OP_OUT    = 4'hD;
  localparam logic [OPC_W-1:0] OP_RSVD_E = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT    = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Opcode sits directly above the DATA_W-wide operand in each instruction word.
  function automatic int opc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int opc_msb(input int data_w);
    return data_w + OPC_W - 1;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - combinational accumulator ALU: new acc value plus carry and update strobes
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  input  logic [DATA_W-1:0] mem_word,
  output logic [DATA_W-1:0] result,
  output logic              carry_out,
  output logic              result_valid,
  output logic              carry_update
);

  logic [DATA_W:0] add_imm;
  logic [DATA_W:0] add_mem;

  assign add_imm = {1'b0, acc} + {1'b0, operand};
  assign add_mem = {1'b0, acc} + {1'b0, mem_word};

  always_comb begin
    result       = acc;
    carry_out    = 1'b0;
    result_valid = 1'b0;
    carry_update = 1'b0;
    case (opcode)
      OP_LDI: begin
        result       = operand;
        result_valid = 1'b1;
      end
      OP_ADDI: begin
        result       = add_imm[DATA_W-1:0];
        carry_out    = add_imm[DATA_W];
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      OP_SUBI: begin
        // carry doubles as borrow on subtract
        result       = acc - operand;
        carry_out    = (acc < operand);
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      OP_ANDI: begin
        result       = acc & operand;
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      OP_ORI: begin
        result       = acc | operand;
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      OP_XORI: begin
        result       = acc ^ operand;
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      OP_LDA: begin
        result       = mem_word;
        result_valid = 1'b1;
      end
      OP_ADDM: begin
        result       = add_mem[DATA_W-1:0];
        carry_out    = add_mem[DATA_W];
        result_valid = 1'b1;
        carry_update = 1'b1;
      end
      default: begin
        result       = acc;
        carry_out    = 1'b0;
        result_valid = 1'b0;
        carry_update = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_cpu.sv
// rtl/acc_cpu.sv - parametrised accumulator CPU top; optional reserved-opcode trap under ACC_CPU_TRAP_EN
module acc_cpu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PADDR_W = 4,
  parameter int DADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    imem_we,
  input  logic [PADDR_W-1:0]      imem_waddr,
  input  logic [OPC_W+DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0]       acc_out,
  output logic [PADDR_W-1:0]      pc_out,
  output logic                    zero,
  output logic                    carry,
  output logic                    running,
  output logic                    halted,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid
`ifdef ACC_CPU_TRAP_EN
  ,
  output logic                    trap
`endif
);

  localparam int OPC_LSB = opc_lsb(DATA_W);
  localparam int OPC_MSB = opc_msb(DATA_W);
  localparam logic [PADDR_W-1:0] PC_ONE = 1;

  logic [OPC_W+DATA_W-1:0] imem [0:(1<<PADDR_W)-1];
  logic [DATA_W-1:0]       dmem [0:(1<<DADDR_W)-1];

  logic [1:0]              state;
  logic [PADDR_W-1:0]      pc;
  logic [DATA_W-1:0]       acc;
  logic                    z_flag;
  logic                    c_flag;

  logic [OPC_W+DATA_W-1:0] instr;
  logic [OPC_W-1:0]        opcode;
  logic [DATA_W-1:0]       operand;
  logic [DADDR_W-1:0]      ea;
  logic [PADDR_W-1:0]      tgt;
  logic [DATA_W-1:0]       mem_word;

  logic [DATA_W-1:0]       alu_result;
  logic                    alu_carry;
  logic                    alu_valid;
  logic                    alu_carry_upd;

  assign instr    = imem[pc];
  assign opcode   = instr[OPC_MSB:OPC_LSB];
  assign operand  = instr[DATA_W-1:0];
  assign ea       = operand[DADDR_W-1:0];
  assign tgt      = operand[PADDR_W-1:0];
  assign mem_word = dmem[ea];

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode       (opcode),
    .acc          (acc),
    .operand      (operand),
    .mem_word     (mem_word),
    .result       (alu_result),
    .carry_out    (alu_carry),
    .result_valid (alu_valid),
    .carry_update (alu_carry_upd)
  );

  // Memories are deliberately outside the reset domain so programs and data survive reset.
  always_ff @(posedge clk) begin
    if (imem_we && state != ST_RUN) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_RUN && opcode == OP_STA) begin
      dmem[ea] <= acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      acc       <= '0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef ACC_CPU_TRAP_EN
      trap      <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (alu_valid) begin
            acc    <= alu_result;
            z_flag <= (alu_result == '0);
          end
          if (alu_carry_upd) begin
            c_flag <= alu_carry;
          end
          pc <= pc + PC_ONE;
          case (opcode)
            OP_JMP: pc <= tgt;
            OP_JZ:  if (z_flag) pc <= tgt;
            OP_JC:  if (c_flag) pc <= tgt;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_HLT: begin
              state <= ST_HALT;
              pc    <= pc;
            end
`ifdef ACC_CPU_TRAP_EN
            OP_RSVD_E: begin
              state <= ST_HALT;
              pc    <= pc;
              trap  <= 1'b1;
            end
`endif
            default: ;
          endcase
        end
        default: begin
          // IDLE and HALT both restart at address 0; HALT keeps acc and flags.
          if (start) begin
            state <= ST_RUN;
            pc    <= '0;
`ifdef ACC_CPU_TRAP_EN
            trap  <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign acc_out = acc;
  assign pc_out  = pc;
  assign zero    = z_flag;
  assign carry   = c_flag;
  assign running = (state == ST_RUN);
  assign halted  = (state == ST_HALT);

endmodule

// File: tb/tb_acc_cpu.sv
// tb/tb_acc_cpu.sv - self-checking bench for acc_cpu with an OUT scoreboard
module tb_acc_cpu;

  logic        clk;
  logic        reset;
  logic        start;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [11:0] imem_wdata;
  logic [7:0]  acc_out;
  logic [3:0]  pc_out;
  logic        zero;
  logic        carry;
  logic        running;
  logic        halted;
  logic [7:0]  out_data;
  logic        out_valid;
`ifdef ACC_CPU_TRAP_EN
  logic        trap;
`endif

  int n_pass;
  int n_total;
  logic [7:0]  sb_q [$];
  logic [11:0] prog [$];
  logic [3:0]  pc_prev;
  logic [3:0]  pc_exp;

  acc_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .acc_out    (acc_out),
    .pc_out     (pc_out),
    .zero       (zero),
    .carry      (carry),
    .running    (running),
    .halted     (halted),
    .out_data   (out_data),
    .out_valid  (out_valid)
`ifdef ACC_CPU_TRAP_EN
    ,
    .trap       (trap)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [11:0] word);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = word;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), (i < prog.size()) ? prog[i] : 12'hF00);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      tick();
    end
    check(tag, halted, 1);
  endtask

  // OUT scoreboard: every pulse must match the oldest expected value.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) check("sb_unexpected_out", {24'h0, out_data}, 32'hFFFF_FFFF);
      else check("sb_out", out_data, sb_q.pop_front());
    end
  end

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    tick(); tick();
    check("rst_acc", acc_out, 0);
    check("rst_pc", pc_out, 0);
    check("rst_flags", {zero, carry}, 0);
    check("rst_state", {running, halted}, 0);
    check("rst_out", {out_valid, out_data}, 0);
    reset = 1'b0;

    // 1: LDI 5, ADDI 3, OUT, HLT
    prog = '{12'h105, 12'h203, 12'hD00, 12'hF00};
    load_prog();
    sb_q.push_back(8'h08);
    do_start();
    check("t1_running", running, 1);
    tick(); tick(); tick();
    check("t1_out_pulse", {out_valid, out_data}, 9'h108);
    tick();
    check("t1_halted", halted, 1);
    check("t1_pc", pc_out, 3);

    // 2: ADD overflow then JC taken; repeat with SUBI borrow
    prog = '{12'h1FF, 12'h201, 12'hC05, 12'hF00, 12'hF00, 12'hF00};
    load_prog();
    do_start();
    wait_halt("t2a_halt", 20);
    check("t2a_pc", pc_out, 5);
    check("t2a_acc", acc_out, 8'h00);
    check("t2a_zc", {zero, carry}, 2'b11);
    prog = '{12'h100, 12'h301, 12'hC05, 12'hF00, 12'hF00, 12'hF00};
    load_prog();
    do_start();
    check("t2b_kept", {acc_out, zero, carry}, {8'h00, 2'b11});
    wait_halt("t2b_halt", 20);
    check("t2b_pc", pc_out, 5);
    check("t2b_acc", acc_out, 8'hFF);
    check("t2b_zc", {zero, carry}, 2'b01);

    // 3: STA/ADDM round trip with JZ taken, then DMEM survives reset
    prog = '{12'h12A, 12'h803, 12'h100, 12'hB05, 12'hF00, 12'h903, 12'hD00, 12'hF00};
    load_prog();
    sb_q.push_back(8'h2A);
    do_start();
    wait_halt("t3a_halt", 20);
    check("t3a_pc", pc_out, 7);
    check("t3a_out", out_data, 8'h2A);
    check("t3a_zc", {zero, carry}, 2'b00);
    do_reset();
    prog = '{12'h903, 12'hF00};
    load_prog();
    do_start();
    wait_halt("t3b_halt", 20);
    check("t3b_acc", acc_out, 8'h2A);
    check("t3b_pc", pc_out, 1);

    // 4: reset mid-RUN clears state asynchronously; IMEM survives
    prog = '{12'h107, 12'hD00, 12'h109, 12'hA02};
    load_prog();
    sb_q.push_back(8'h07);
    do_start();
    for (int i = 0; i < 8; i++) tick();
    check("t4_loop", {running, acc_out, out_data}, {1'b1, 8'h09, 8'h07});
    #2 reset = 1'b1;
    #1;
    check("t4_async_state", {running, halted}, 0);
    check("t4_async_regs", {acc_out, pc_out, zero, carry, out_data, out_valid}, 0);
    tick();
    reset = 1'b0;
    sb_q.push_back(8'h07);
    do_start();
    for (int i = 0; i < 5; i++) tick();
    check("t4_resume", {running, acc_out, out_data}, {1'b1, 8'h09, 8'h07});
    do_reset();

    // 5: IMEM write and start are ignored while running
    prog = '{12'h100, 12'h201, 12'hC04, 12'hA01, 12'hF00};
    load_prog();
    do_start();
    for (int i = 0; i < 10; i++) tick();
    pc_prev = pc_out;
    pc_exp = (pc_prev == 4'd3) ? 4'd1 : pc_prev + 4'd1;
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 12'hF00; start = 1'b1;
    tick();
    imem_we = 1'b0; start = 1'b0;
    check("t5_start_ignored", pc_out, pc_exp);
    wait_halt("t5_halt", 2000);
    check("t5_final", {pc_out, acc_out, zero, carry}, {4'd4, 8'h00, 2'b11});
    do_start();
    tick(); tick();
    check("t5_write_ignored", running, 1);
    wait_halt("t5_halt2", 2000);
    write_word(4'd0, 12'hF00);
    do_start();
    tick();
    check("t5_write_taken", {halted, pc_out}, {1'b1, 4'd0});

    // 6: reserved opcode E
    prog = '{12'hE00, 12'hF00};
    load_prog();
    do_start();
    wait_halt("t6_halt", 20);
`ifdef ACC_CPU_TRAP_EN
    check("t6_trap", {trap, pc_out}, {1'b1, 4'd0});
    do_start();
    check("t6_trap_clear", trap, 0);
`else
    check("t6_nop_pc", pc_out, 1);
`endif

    tick(); tick();
    check("sb_leftover", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
